// File: rtl/oclib_pkg.sv
// Shared types and register addresses for the chip-monitor DRP model.
package oclib_pkg;

  typedef struct packed {
    logic        enable;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } drp_s;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
  } drp_fb_s;

  typedef enum logic {
    StIdle,
    StBusy
  } chipmon_state_e;

  localparam logic [7:0] ChipMonAddrTemp      = 8'h00;
  localparam logic [7:0] ChipMonAddrStatus    = 8'h3F;
  localparam logic [7:0] ChipMonAddrAlarmHigh = 8'h50;
  localparam logic [7:0] ChipMonAddrOtHigh    = 8'h53;
  localparam logic [7:0] ChipMonAddrAlarmLow  = 8'h54;
  localparam logic [7:0] ChipMonAddrOtLow     = 8'h57;

  function automatic logic [15:0] chipMonStatus(input logic protocolError,
                                                input logic warning,
                                                input logic error);
    return {13'b0, error, warning, protocolError};
  endfunction

endpackage

// File: rtl/oclib_hysteresis_compare.sv
// Unsigned threshold compare with hysteresis; flag follows a valid sample one cycle later.
module oclib_hysteresis_compare (
  input  logic        clock,
  input  logic        resetN,
  input  logic [15:0] value,
  input  logic        valid,
  input  logic [15:0] high,
  input  logic [15:0] low,
  output logic        flag
);

  // Between low and high the previous decision is held.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      flag <= 1'b0;
    end else if (valid) begin
      if (value >= high) begin
        flag <= 1'b1;
      end else if (value < low) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/oc_chipmon_model.sv
// Behavioural SYSMON-style chip monitor behind a DRP port with fixed-latency ready.
// Alarm/over-temperature logic is built only when OC_CHIPMON_MODEL_ALARM_EN is defined.
module oc_chipmon_model
  import oclib_pkg::*;
#(
  parameter int          ReadyLatency  = 2,
  parameter logic [15:0] AlarmHighInit = 16'hB7A0,
  parameter logic [15:0] AlarmLowInit  = 16'hB6A0,
  parameter logic [15:0] OtHighInit    = 16'hBB60,
  parameter logic [15:0] OtLowInit     = 16'hBA60
) (
  input  logic        clock,
  input  logic        resetN,
  input  drp_s        drp,
  output drp_fb_s     drpFb,
  input  logic [15:0] tempCode,
  input  logic        tempValid,
  output logic        thermalWarning,
  output logic        thermalError
);

  localparam logic [3:0] LatCount = ReadyLatency[3:0];

  chipmon_state_e state;
  logic [3:0]     count;
  logic           readyQ;
  logic           writeQ;
  logic [7:0]     addrQ;
  logic [15:0]    wdataQ;
  logic [15:0]    tempReg;
  logic           protocolError;
  logic [15:0]    alarmHigh;
  logic [15:0]    alarmLow;
  logic [15:0]    otHigh;
  logic [15:0]    otLow;
  logic [15:0]    readValue;
  logic           accept;
  logic           busyHit;
  logic           commit;
  logic           unusedBits;

  // The ready cycle doubles as an accept slot so transactions can run back to back.
  assign accept  = drp.enable && ((state == StIdle) || readyQ);
  assign busyHit = drp.enable && (state == StBusy) && !readyQ;
  assign commit  = readyQ && writeQ;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state  <= StIdle;
      count  <= 4'd0;
      readyQ <= 1'b0;
      writeQ <= 1'b0;
      addrQ  <= 8'd0;
      wdataQ <= 16'd0;
    end else begin
      readyQ <= 1'b0;
      if (accept) begin
        state  <= StBusy;
        count  <= LatCount;
        writeQ <= drp.write;
        addrQ  <= drp.address[7:0];
        wdataQ <= drp.wdata[15:0];
        readyQ <= (ReadyLatency == 1);
      end else if (state == StBusy) begin
        count <= count - 4'd1;
        if (count == 4'd2) begin
          readyQ <= 1'b1;
        end
        if (count == 4'd1) begin
          state <= StIdle;
        end
      end
    end
  end

  // A protocol violation wins over a same-cycle clear.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      protocolError <= 1'b0;
    end else if (busyHit) begin
      protocolError <= 1'b1;
    end else if (commit && (addrQ == ChipMonAddrStatus) && wdataQ[0]) begin
      protocolError <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      tempReg <= 16'd0;
    end else if (tempValid) begin
      tempReg <= tempCode;
    end
  end

`ifdef OC_CHIPMON_MODEL_ALARM_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      alarmHigh <= AlarmHighInit;
      alarmLow  <= AlarmLowInit;
      otHigh    <= OtHighInit;
      otLow     <= OtLowInit;
    end else if (commit) begin
      case (addrQ)
        ChipMonAddrAlarmHigh: alarmHigh <= wdataQ;
        ChipMonAddrAlarmLow:  alarmLow  <= wdataQ;
        ChipMonAddrOtHigh:    otHigh    <= wdataQ;
        ChipMonAddrOtLow:     otLow     <= wdataQ;
        default: ;
      endcase
    end
  end

  oclib_hysteresis_compare uWarning (
    .clock  (clock),
    .resetN (resetN),
    .value  (tempCode),
    .valid  (tempValid),
    .high   (alarmHigh),
    .low    (alarmLow),
    .flag   (thermalWarning)
  );

  oclib_hysteresis_compare uError (
    .clock  (clock),
    .resetN (resetN),
    .value  (tempCode),
    .valid  (tempValid),
    .high   (otHigh),
    .low    (otLow),
    .flag   (thermalError)
  );
`else
  logic unusedCfg;

  assign alarmHigh      = 16'd0;
  assign alarmLow       = 16'd0;
  assign otHigh         = 16'd0;
  assign otLow          = 16'd0;
  assign thermalWarning = 1'b0;
  assign thermalError   = 1'b0;
  assign unusedCfg      = ^{AlarmHighInit, AlarmLowInit, OtHighInit, OtLowInit};
`endif

  always_comb begin
    readValue = 16'd0;
    case (addrQ)
      ChipMonAddrTemp:      readValue = tempReg;
      ChipMonAddrStatus:    readValue = chipMonStatus(protocolError, thermalWarning, thermalError);
      ChipMonAddrAlarmHigh: readValue = alarmHigh;
      ChipMonAddrAlarmLow:  readValue = alarmLow;
      ChipMonAddrOtHigh:    readValue = otHigh;
      ChipMonAddrOtLow:     readValue = otLow;
      default:              readValue = 16'd0;
    endcase
  end

  // rdata is forced to zero outside the ready cycle.
  always_comb begin
    drpFb       = '0;
    drpFb.ready = readyQ;
    if (readyQ) begin
      drpFb.rdata = {16'd0, readValue};
    end
  end

  assign unusedBits = ^{drp.address[31:8], drp.wdata[31:16], wdataQ};

endmodule
